// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder types and sign-magnitude message helpers.
// Helpers take a 32-bit container plus the live message width so that any MSG_W <= 32 can use them.
package ldpc_pkg;

    localparam int MSG_W_DEF = 8;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } cnu_state_t;

    function automatic logic msg_sign(input logic [31:0] msg, input int w);
        return msg[w-1];
    endfunction

    function automatic logic [31:0] msg_mag(input logic [31:0] msg, input int w);
        return msg & ((32'd1 << (w - 1)) - 32'd1);
    endfunction

    // A zero magnitude is always emitted as +0, never -0.
    function automatic logic [31:0] mk_msg(input logic sign, input logic [31:0] mag, input int w);
        return (mag == 32'd0) ? 32'd0 : (({31'd0, sign} << (w - 1)) | mag);
    endfunction

endpackage

// File: rtl/cnu_min_tracker.sv
// Running smallest / second-smallest magnitude tracker with the index of the smallest.
// The next-state values are exported so a caller can act on the result of the final update.
module cnu_min_tracker #(
    parameter int MAG_W = 7,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             upd,
    input  logic [MAG_W-1:0] mag,
    input  logic [IDX_W-1:0] idx,
    output logic [MAG_W-1:0] min1,
    output logic [MAG_W-1:0] min2,
    output logic [IDX_W-1:0] min_idx,
    output logic [MAG_W-1:0] nxt_min1,
    output logic [MAG_W-1:0] nxt_min2,
    output logic [IDX_W-1:0] nxt_min_idx
);

    always_comb begin
        nxt_min1    = min1;
        nxt_min2    = min2;
        nxt_min_idx = min_idx;
        if (clr) begin
            nxt_min1    = '1;
            nxt_min2    = '1;
            nxt_min_idx = '0;
        end else if (upd) begin
            // Strict compares: on a tie the earlier arrival keeps min1 and the newcomer lands in min2.
            if (mag < min1) begin
                nxt_min2    = min1;
                nxt_min1    = mag;
                nxt_min_idx = idx;
            end else if (mag < min2) begin
                nxt_min2 = mag;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min1    <= '1;
            min2    <= '1;
            min_idx <= '0;
        end else begin
            min1    <= nxt_min1;
            min2    <= nxt_min2;
            min_idx <= nxt_min_idx;
        end
    end

endmodule

// File: rtl/cnu_minsum_serial.sv
// Serial offset min-sum check node: collects DC messages, then emits DC extrinsic replies
// plus a parity-satisfied flag. Output fields are registered and held across backpressure.
module cnu_minsum_serial
    import ldpc_pkg::*;
#(
    parameter int MSG_W  = MSG_W_DEF,
    parameter int DC     = 6,
    parameter int OFFSET = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cnu_en,
    input  logic                  msg_in_valid,
    output logic                  msg_in_ready,
    input  logic [MSG_W-1:0]      msg_from_var,
    output logic                  msg_out_valid,
    input  logic                  msg_out_ready,
    output logic [MSG_W-1:0]      msg_to_var,
    output logic [$clog2(DC)-1:0] msg_out_idx,
    output logic                  parity_ok,
    output logic                  cnu_over
);

    localparam int MAG_W = MSG_W - 1;
    localparam int IDX_W = $clog2(DC);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DC - 1);

    cnu_state_t       state;
    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] out_cnt;
    logic [IDX_W-1:0] nxt_j;
    logic [DC-1:0]    sign_reg;
    logic             sign_xor;
    logic             sx_nxt;

    logic             in_sign;
    logic [MAG_W-1:0] in_mag;
    logic             accept;
    logic             last_in;
    logic             xfer;
    logic             last_out;

    logic [MAG_W-1:0] min1, min2, nxt_min1, nxt_min2;
    logic [IDX_W-1:0] min_idx, nxt_min_idx;

    assign msg_in_ready = (state == COLLECT) && cnu_en;
    assign in_sign      = msg_sign(32'(msg_from_var), MSG_W);
    assign in_mag       = MAG_W'(msg_mag(32'(msg_from_var), MSG_W));
    assign accept       = msg_in_valid && msg_in_ready;
    assign last_in      = accept && (cnt == LAST);
    assign xfer         = msg_out_valid && msg_out_ready;
    assign last_out     = xfer && (out_cnt == LAST);
    assign sx_nxt       = sign_xor ^ in_sign;
    assign nxt_j        = out_cnt + 1'b1;

    cnu_min_tracker #(
        .MAG_W (MAG_W),
        .IDX_W (IDX_W)
    ) u_min (
        .clk         (clk),
        .rst         (rst),
        .clr         (last_out),
        .upd         (accept),
        .mag         (in_mag),
        .idx         (cnt),
        .min1        (min1),
        .min2        (min2),
        .min_idx     (min_idx),
        .nxt_min1    (nxt_min1),
        .nxt_min2    (nxt_min2),
        .nxt_min_idx (nxt_min_idx)
    );

    // Extrinsic reply for index j: exclude j's own magnitude, apply offset with a floor at 0.
    function automatic logic [MSG_W-1:0] c2v(
        input logic [IDX_W-1:0] j,
        input logic [MAG_W-1:0] m1,
        input logic [MAG_W-1:0] m2,
        input logic [IDX_W-1:0] mi,
        input logic             sgn
    );
        logic [31:0] m;
        m = (j == mi) ? 32'(m2) : 32'(m1);
        m = (m > $unsigned(OFFSET)) ? m - $unsigned(OFFSET) : 32'd0;
        return MSG_W'(mk_msg(sgn, m, MSG_W));
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= COLLECT;
            cnt           <= '0;
            out_cnt       <= '0;
            sign_reg      <= '0;
            sign_xor      <= 1'b0;
            msg_out_valid <= 1'b0;
            msg_to_var    <= '0;
            msg_out_idx   <= '0;
            parity_ok     <= 1'b0;
            cnu_over      <= 1'b0;
        end else begin
            cnu_over <= 1'b0;
            case (state)
                COLLECT: begin
                    if (accept) begin
                        sign_reg[cnt] <= in_sign;
                        sign_xor      <= sx_nxt;
                        if (last_in) begin
                            // First reply is built from the post-update minima and sign parity.
                            cnt           <= '0;
                            out_cnt       <= '0;
                            state         <= EMIT;
                            msg_out_valid <= 1'b1;
                            msg_out_idx   <= '0;
                            parity_ok     <= ~sx_nxt;
                            msg_to_var    <= c2v('0, nxt_min1, nxt_min2, nxt_min_idx,
                                                 sx_nxt ^ sign_reg[0]);
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (last_out) begin
                        state         <= COLLECT;
                        out_cnt       <= '0;
                        sign_reg      <= '0;
                        sign_xor      <= 1'b0;
                        msg_out_valid <= 1'b0;
                        msg_to_var    <= '0;
                        msg_out_idx   <= '0;
                        parity_ok     <= 1'b0;
                        cnu_over      <= 1'b1;
                    end else if (xfer) begin
                        out_cnt     <= nxt_j;
                        msg_out_idx <= nxt_j;
                        msg_to_var  <= c2v(nxt_j, min1, min2, min_idx,
                                           sign_xor ^ sign_reg[nxt_j]);
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_cnu_minsum_serial.sv
// Directed + randomized check of the serial min-sum CNU, run in parallel at OFFSET 0 and 1.
// Expected replies come from the min-over-others definition of min-sum, not the min1/min2 shortcut.
module tb_cnu_minsum_serial;

    localparam int MSG_W = 8;
    localparam int DC    = 6;
    localparam int IW    = $clog2(DC);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cnu_en = 1'b1;
    logic             msg_in_valid = 1'b0;
    logic [MSG_W-1:0] msg_from_var = '0;
    logic             msg_out_ready = 1'b0;

    logic             in_rdy0, in_rdy1, ov0, ov1, par0, par1, over0, over1;
    logic [MSG_W-1:0] to0, to1;
    logic [IW-1:0]    idx0, idx1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cnu_minsum_serial #(.MSG_W(MSG_W), .DC(DC), .OFFSET(0)) dut0 (
        .clk(clk), .rst(rst), .cnu_en(cnu_en), .msg_in_valid(msg_in_valid),
        .msg_in_ready(in_rdy0), .msg_from_var(msg_from_var), .msg_out_valid(ov0),
        .msg_out_ready(msg_out_ready), .msg_to_var(to0), .msg_out_idx(idx0),
        .parity_ok(par0), .cnu_over(over0));

    cnu_minsum_serial #(.MSG_W(MSG_W), .DC(DC), .OFFSET(1)) dut1 (
        .clk(clk), .rst(rst), .cnu_en(cnu_en), .msg_in_valid(msg_in_valid),
        .msg_in_ready(in_rdy1), .msg_from_var(msg_from_var), .msg_out_valid(ov1),
        .msg_out_ready(msg_out_ready), .msg_to_var(to1), .msg_out_idx(idx1),
        .parity_ok(par1), .cnu_over(over1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_out(input logic [7:0] m[DC], input int j, input int off);
        int  best = 127;
        bit  s = 1'b0;
        for (int k = 0; k < DC; k++) begin
            if (k != j) begin
                s ^= m[k][7];
                if (int'(m[k][6:0]) < best) best = int'(m[k][6:0]);
            end
        end
        best = (best > off) ? best - off : 0;
        return (best == 0) ? 8'h00 : {s, 7'(best)};
    endfunction

    function automatic logic ref_parity(input logic [7:0] m[DC]);
        logic s = 1'b0;
        for (int k = 0; k < DC; k++) s ^= m[k][7];
        return ~s;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_in_ready0"}, 32'(in_rdy0), 32'(cnu_en));
        chk({tag, "_in_ready1"}, 32'(in_rdy1), 32'(cnu_en));
        chk({tag, "_valid"}, {30'd0, ov0, ov1}, 32'd0);
        chk({tag, "_to_var"}, {16'd0, to0, to1}, 32'd0);
        chk({tag, "_idx_par"}, {26'd0, idx0, idx1}, 32'd0);
        chk({tag, "_par_over"}, {28'd0, par0, par1, over0, over1}, 32'd0);
    endtask

    // gap_at >= 0 drops cnu_en for 3 cycles before accepting message gap_at.
    task automatic send_frame(input logic [7:0] m[DC], input int gap_at);
        int i = 0, guard = 0, gap = 0;
        while (i < DC && guard < 200) begin
            @(negedge clk);
            guard++;
            msg_in_valid = 1'b1;
            msg_from_var = m[i];
            cnu_en = !(i == gap_at && gap < 3);
            #1;
            if (!cnu_en) begin
                gap++;
                chk("in_ready_gated", {30'd0, in_rdy0, in_rdy1}, 32'd0);
            end else if (in_rdy0 && in_rdy1) begin
                i++;
            end
        end
        chk("send_timeout", 32'(guard < 200), 32'd1);
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready and cnu_en.
    task automatic recv_frame(input logic [7:0] m[DC], input int mode, input int nstop);
        int  j = 0, cyc = 0;
        bit  r;
        logic [3:0] pat = 4'b1001;
        while (j < nstop && cyc < 300) begin
            @(negedge clk);
            msg_in_valid = 1'b0;
            chk("out_valid", {30'd0, ov0, ov1}, 32'h3);
            chk("out_idx", {26'd0, idx0, idx1}, {26'd0, IW'(j), IW'(j)});
            chk("to_var_off0", 32'(to0), 32'(ref_out(m, j, 0)));
            chk("to_var_off1", 32'(to1), 32'(ref_out(m, j, 1)));
            chk("parity_ok", {30'd0, par0, par1}, {30'd0, {2{ref_parity(m)}}});
            chk("over_low", {30'd0, over0, over1}, 32'd0);
            chk("in_ready_emit", {30'd0, in_rdy0, in_rdy1}, 32'd0);
            case (mode)
                0:       r = 1'b1;
                1:       r = pat[3 - (cyc % 4)];
                default: begin r = 1'($urandom); cnu_en = 1'($urandom); end
            endcase
            msg_out_ready = r;
            if (r) j++;
            cyc++;
        end
        chk("recv_timeout", 32'(cyc < 300), 32'd1);
        if (nstop == DC) begin
            @(negedge clk);
            msg_out_ready = 1'b0;
            cnu_en = 1'b1;
            #1;
            chk("over_pulse", {30'd0, over0, over1}, 32'h3);
            chk("in_ready_back", {30'd0, in_rdy0, in_rdy1}, 32'h3);
            chk("valid_drop", {30'd0, ov0, ov1}, 32'd0);
            @(negedge clk);
            chk("over_one_cycle", {30'd0, over0, over1}, 32'd0);
        end
    endtask

    logic [7:0] f1[DC];
    logic [7:0] f2[DC];
    logic [7:0] f4[DC];
    logic [7:0] fr[DC];

    initial begin
        f1 = '{8'h05, 8'h83, 8'h07, 8'h82, 8'h09, 8'h04};
        f2 = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h04, 8'h04};
        f4 = '{8'h81, 8'h01, 8'h03, 8'h03, 8'h03, 8'h03};

        #1;
        chk_idle("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_idle("post_reset");

        // Case 1 reference: +2,-2,+2,-3,+2,+2 at OFFSET 0
        chk("case1_ref_j3", 32'(ref_out(f1, 3, 0)), 32'h83);
        send_frame(f1, -1);
        recv_frame(f1, 0, DC);

        send_frame(f2, -1);
        recv_frame(f2, 0, DC);

        send_frame(f1, -1);
        recv_frame(f1, 1, DC);

        send_frame(f4, -1);
        recv_frame(f4, 0, DC);

        // Mid-frame reset after the third output is accepted
        send_frame(f1, -1);
        recv_frame(f1, 0, 3);
        @(negedge clk);
        msg_out_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk_idle("async_reset");
        @(negedge clk);
        rst = 1'b0;
        send_frame(f2, -1);
        recv_frame(f2, 0, DC);

        send_frame(f1, 2);
        recv_frame(f1, 0, DC);

        for (int n = 0; n < 12; n++) begin
            for (int k = 0; k < DC; k++) begin
                fr[k] = (n % 2 == 0) ? 8'($urandom) : {1'($urandom), 7'($urandom_range(0, 3))};
            end
            send_frame(fr, (n % 3 == 0) ? int'($urandom_range(0, DC - 1)) : -1);
            recv_frame(fr, n % 3, DC);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
